// File: rtl/sprite_palette_engine.sv
// Multi-bank sprite palette lookup with greyscale init,
// transparency keying, 2-stage read pipe and hit-flash.
module sprite_palette_engine #(
  parameter int INDEX_W      = 4,
  parameter int CH_W         = 4,
  parameter int NUM_PAL      = 4,
  parameter int TRANSP_IDX   = 1,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       pix_valid,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [INDEX_W-1:0]         index,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [INDEX_W-1:0]         wr_idx,
  input  logic [3*CH_W-1:0]          wr_rgb,
  input  logic                       flash_trig,
  output logic [CH_W-1:0]            red,
  output logic [CH_W-1:0]            green,
  output logic [CH_W-1:0]            blue,
  output logic                       transparent,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       flash_active
);

  localparam int PAL_W = $clog2(NUM_PAL);
  localparam int AW    = PAL_W + INDEX_W;
  localparam int DEPTH = 1 << AW;
  localparam int RGB_W = 3 * CH_W;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state;
  logic [AW-1:0]     init_addr;
  logic [RGB_W-1:0]  mem [DEPTH];

  logic              run;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [RGB_W-1:0]  mem_wdata;
  logic [CH_W-1:0]   grey;

  logic              s1_valid;
  logic              s1_transp;
  logic [RGB_W-1:0]  s1_rgb;
  logic [7:0]        flash_cnt;

  assign run = (state == RUN);

  // Select the RAM write source: initialiser ramp or host write
  always_comb begin
    grey      = CH_W'(init_addr[INDEX_W-1:0]);
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = {grey, grey, grey};
    if (!reset) begin
      if (!run) begin
        mem_we = 1'b1;
      end else if (wr_en) begin
        mem_we    = 1'b1;
        mem_waddr = {wr_pal, wr_idx};
        mem_wdata = wr_rgb;
      end
    end
  end

  // Palette RAM write port
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Init/run control: walk every entry once, then release busy
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_addr <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          init_addr <= init_addr + 1'b1;
          if (&init_addr) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Stage 1: RAM read and transparency compare
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_rgb    <= '0;
    end else begin
      s1_valid <= run & pix_valid;
      if (run & pix_valid) begin
        s1_rgb    <= mem[{pal_sel, index}];
        s1_transp <= (index == INDEX_W'(TRANSP_IDX));
      end
    end
  end

  // Flash frame counter; a trigger beats a same-cycle frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cnt    <= '0;
      flash_active <= 1'b0;
    end else if (run) begin
      if (flash_trig) begin
        flash_cnt    <= 8'(FLASH_FRAMES);
        flash_active <= 1'b1;
      end else if (flash_active && frame_start) begin
        flash_cnt <= flash_cnt - 8'd1;
        if (flash_cnt == 8'd1)
          flash_active <= 1'b0;
      end
    end
  end

  // Stage 2: apply flash to opaque pixels and register outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= s1_transp;
        if (flash_active && !s1_transp) begin
          red   <= '1;
          green <= '1;
          blue  <= '1;
        end else begin
          red   <= s1_rgb[3*CH_W-1:2*CH_W];
          green <= s1_rgb[2*CH_W-1:CH_W];
          blue  <= s1_rgb[CH_W-1:0];
        end
      end
    end
  end

endmodule

// File: doc/sprite_palette_engine.md
Name: sprite_palette_engine

Overview:
- Runtime-writable, multi-bank sprite colour lookup for the VGA sprite path.
- Maps a per-pixel colour index to CH_W-bit RGB through one of NUM_PAL selectable palettes, e.g. player 1, player 2 alternate and hit-flash sets.
- Adds a built-in reset initialiser, transparency keying, a pipelined registered output and a frame-counted hit-flash effect.
- Sits between the sprite ROM index output and the frame compositor.

Parameters:
- INDEX_W, 4: colour index width; each palette holds 2**INDEX_W entries.
- CH_W, 4: bits per colour channel.
- NUM_PAL, 4: number of palette banks; must be a power of two, at least 2.
- TRANSP_IDX, 1: index treated as transparent in every bank.
- FLASH_FRAMES, 8: frames the flash effect lasts; range 1..255.

Ports:
- Clk  in  1: system clock.
- Reset  in  1: synchronous, active-high reset.
- frame_start  in  1: one-cycle pulse per frame (vsync edge).
- pix_valid  in  1: index/pal_sel qualify this cycle.
- pal_sel  in  log2(NUM_PAL): palette bank for this pixel.
- index  in  INDEX_W: colour index for this pixel.
- wr_en  in  1: palette write strobe.
- wr_pal  in  log2(NUM_PAL): bank to write.
- wr_idx  in  INDEX_W: entry to write.
- wr_rgb  in  3*CH_W: write data, packed {R,G,B}.
- flash_trig  in  1: start or restart the flash effect.
- red, green, blue  out  CH_W each: registered colour.
- transparent  out  1: output pixel is keyed out.
- out_valid  out  1: red/green/blue/transparent are valid.
- busy  out  1: initialiser running; lookups and writes are ignored.
- flash_active  out  1: flash effect in progress.

Behaviour:
- FSM states: INIT and RUN.
- Reset, from any state and even mid-pipeline: go to INIT, zero the init address and flush the pipeline.
  - Reset values: red/green/blue=0, transparent=0, out_valid=0, flash_active=0, busy=1.
- INIT:
  - Writes one entry per cycle, bank-major, NUM_PAL*2**INDEX_W cycles in total (64 with defaults).
  - Default entry value for bank b, index i: every channel = i[CH_W-1:0] (greyscale ramp), for every bank.
  - wr_en, pix_valid and flash_trig are ignored while in INIT.
  - After the last entry: enter RUN and drop busy to 0 on the following cycle.
- RUN lookup is a 2-stage pipeline; latency is exactly 2 cycles from pix_valid to out_valid.
  - Stage 1 registers the RAM read of {pal_sel,index} and the comparison index==TRANSP_IDX.
  - Stage 2 applies the flash effect and registers the outputs.
  - out_valid equals pix_valid delayed 2 cycles; throughput is one pixel per cycle, no back-pressure.
  - When out_valid=0, the colour outputs hold their last values.
- Transparency:
  - transparent=1 whenever the index equals TRANSP_IDX, in any bank.
  - The colour outputs still carry the stored RAM value in that case.
  - Flash is never applied to transparent pixels.
- Writes (RUN only):
  - Take effect at the clock edge where wr_en=1.
  - Read-first rule: a same-cycle write and lookup of the same entry returns the old value; a lookup one cycle later returns the new value.
  - Writing entry TRANSP_IDX is allowed; it changes the colour but not the keying.
- Flash:
  - flash_trig in RUN loads frame counter = FLASH_FRAMES and sets flash_active=1 on the next cycle.
  - Each frame_start while active decrements the counter; reaching 0 clears flash_active in the same edge.
  - flash_trig and frame_start on the same cycle: the trigger wins and the counter reloads to FLASH_FRAMES with no decrement.
  - flash_trig while active: restarts the count.
  - While active, stage 2 forces every channel of non-transparent pixels to all ones (4'hF).
  - The flash state is sampled at stage 2, so a pixel in flight when flash_active rises is flashed.
- Widths:
  - Address = {pal_sel,index}.
  - Out-of-range values are impossible because NUM_PAL is a power of two.

Test Plan:
- Reset, then hold pix_valid=0 -> busy=1 for exactly 64 cycles, then 0; lookup bank 2 index 7 -> after 2 cycles out_valid=1, RGB=7/7/7, transparent=0.
- Write bank 1 idx 3 = 12'hC10, with a lookup of bank 1 idx 3 in the same cycle and again one cycle later -> first result 3/3/3, second result C/1/0, each 2 cycles after its lookup.
- Stream of 6 back-to-back pixels including index 1 (TRANSP_IDX) -> 6 consecutive out_valid cycles, with transparent=1 only on the index-1 pixel, in order.
- flash_trig, then index 5 lookups across frames -> 4'hF/4'hF/4'hF while active; flash_active falls at the 8th frame_start; next lookup gives 5/5/5; index 1 stays transparent=1 with no forcing throughout.
- flash_trig coincident with frame_start, and a retrigger after 5 frames -> counter reloads with no decrement; flash_active persists 8 more frames after the retrigger.
- Assert Reset for 1 cycle mid-stream during flash -> next cycle out_valid=0, flash_active=0, busy=1; written colours are overwritten back to greyscale after INIT.
